// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared types and constants for the TX frame arbiter
package tx_arb_pkg;

    typedef enum logic [1:0] {IDLE, XFER, GAP, PAUSED} arb_state_t;

    localparam int PAUSE_QUANTUM_CYC = 8;
    localparam int MOD_W             = 3;
    localparam int PAUSE_W           = 19;
    localparam int GAP_W             = 4;

endpackage

// File: rtl/tx_rr_picker.sv
// tx_rr_picker: combinational round-robin priority encoder searching upward from ptr with wrap
module tx_rr_picker #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // scan from the farthest offset down so the nearest requester to ptr wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                idx   = W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: frame-granular round-robin scheduler onto the MAC TX packet interface with gap and PAUSE handling
module tx_frame_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int MIN_GAP = 1
) (
    input  logic                     clk_156m25,
    input  logic                     reset_156m25,
    input  logic [NUM_REQ-1:0]       req_val,
    input  logic [NUM_REQ-1:0]       req_sop,
    input  logic [NUM_REQ-1:0]       req_eop,
    input  logic [NUM_REQ*MOD_W-1:0] req_mod,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_rdy,
    input  logic                     pkt_tx_full,
    output logic                     pkt_tx_val,
    output logic                     pkt_tx_sop,
    output logic                     pkt_tx_eop,
    output logic [MOD_W-1:0]         pkt_tx_mod,
    output logic [DATA_W-1:0]        pkt_tx_data,
    input  logic                     pause_req,
    input  logic [15:0]              pause_quanta,
    output logic                     paused,
    output logic [2:0]               grant_id,
    output logic [31:0]              frame_cnt,
    output logic                     err_nosop
);

    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t          state, state_nxt;
    logic [RW-1:0]       rr_ptr, grant, pick_idx, rr_nxt;
    logic                pick_found;
    logic [GAP_W-1:0]    gap_cnt;
    logic [PAUSE_W-1:0]  pause_tmr;
    logic                g_val, g_sop, g_eop;
    logic [MOD_W-1:0]    g_mod;
    logic [DATA_W-1:0]   g_data;
    logic                xfer, idle_arb, drain, eop_acc;

    tx_rr_picker #(.N(NUM_REQ), .W(RW)) u_picker (
        .req   (req_val & req_sop),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign g_val  = req_val[grant];
    assign g_sop  = req_sop[grant];
    assign g_eop  = req_eop[grant];
    assign g_mod  = req_mod[grant*MOD_W +: MOD_W];
    assign g_data = req_data[grant*DATA_W +: DATA_W];

    // outputs are gated by reset so nothing leaks to the MAC while reset is held
    assign xfer     = (state == XFER) && !reset_156m25;
    assign idle_arb = (state == IDLE) && (pause_tmr == '0) && !reset_156m25;
    assign drain    = idle_arb && !pick_found && (|req_val);
    assign eop_acc  = pkt_tx_val & g_eop;
    assign rr_nxt   = (grant == RW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    assign pkt_tx_val  = xfer & g_val & ~pkt_tx_full;
    assign pkt_tx_sop  = pkt_tx_val & g_sop;
    assign pkt_tx_eop  = pkt_tx_val & g_eop;
    assign pkt_tx_mod  = xfer ? g_mod : '0;
    assign pkt_tx_data = xfer ? g_data : '0;
    assign paused      = (pause_tmr != '0) && !reset_156m25;
    assign grant_id    = 3'(grant);

    // ready goes to the granted source in XFER, or to stray non-SOP beats being drained in IDLE
    always_comb begin
        req_rdy = drain ? req_val : '0;
        if (xfer)
            req_rdy[grant] = ~pkt_tx_full;
    end

    // next-state: pause is only honoured from IDLE, so frames in flight always complete
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (pause_tmr != '0) ? PAUSED : (pick_found ? XFER : IDLE);
            XFER:    state_nxt = eop_acc ? ((MIN_GAP > 0) ? GAP : IDLE) : XFER;
            GAP:     state_nxt = (gap_cnt <= GAP_W'(1)) ? IDLE : GAP;
            PAUSED:  state_nxt = (pause_tmr == '0) ? IDLE : PAUSED;
            default: state_nxt = IDLE;
        endcase
    end

    // state register, grant latch and round-robin pointer
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (idle_arb && pick_found)
                grant <= pick_idx;
            if (eop_acc)
                rr_ptr <= rr_nxt;
        end
    end

    // inter-frame gap counter, loaded at EOP and run down in GAP
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25)
            gap_cnt <= '0;
        else if (eop_acc)
            gap_cnt <= GAP_W'(MIN_GAP);
        else if (state == GAP && gap_cnt != '0)
            gap_cnt <= gap_cnt - 1'b1;
    end

    // pause timer in cycles; a new request always overrides the running count
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25)
            pause_tmr <= '0;
        else if (pause_req)
            pause_tmr <= PAUSE_W'(pause_quanta) << $clog2(PAUSE_QUANTUM_CYC);
        else if (pause_tmr != '0)
            pause_tmr <= pause_tmr - 1'b1;
    end

    // completed-frame counter and sticky framing error
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            frame_cnt <= '0;
            err_nosop <= 1'b0;
        end else begin
            if (eop_acc)
                frame_cnt <= frame_cnt + 1'b1;
            if (drain)
                err_nosop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb_tx_frame_arbiter: directed table and sequence checks for tx_frame_arbiter
module tb_tx_frame_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_val, req_sop, req_eop, req_rdy;
    logic [N*3-1:0] req_mod;
    logic [N*64-1:0] req_data;
    logic           full, pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
    logic [2:0]     pkt_tx_mod;
    logic [63:0]    pkt_tx_data;
    logic           pause_req, paused, err_nosop;
    logic [15:0]    pause_quanta;
    logic [2:0]     grant_id;
    logic [31:0]    frame_cnt;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    tx_frame_arbiter #(.NUM_REQ(N), .DATA_W(64), .MIN_GAP(1)) dut (
        .clk_156m25   (clk),
        .reset_156m25 (rst),
        .req_val      (req_val),
        .req_sop      (req_sop),
        .req_eop      (req_eop),
        .req_mod      (req_mod),
        .req_data     (req_data),
        .req_rdy      (req_rdy),
        .pkt_tx_full  (full),
        .pkt_tx_val   (pkt_tx_val),
        .pkt_tx_sop   (pkt_tx_sop),
        .pkt_tx_eop   (pkt_tx_eop),
        .pkt_tx_mod   (pkt_tx_mod),
        .pkt_tx_data  (pkt_tx_data),
        .pause_req    (pause_req),
        .pause_quanta (pause_quanta),
        .paused       (paused),
        .grant_id     (grant_id),
        .frame_cnt    (frame_cnt),
        .err_nosop    (err_nosop)
    );

    typedef struct {
        int         src;
        logic       v, s, e;
        logic [2:0] m;
        logic       f;
        logic       ev, es, ee;
        logic [2:0] em;
        logic [3:0] erdy;
        logic [2:0] egid;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clr_in();
        req_val = '0; req_sop = '0; req_eop = '0; req_mod = '0; req_data = '0;
        full = 1'b0; pause_req = 1'b0; pause_quanta = '0;
    endtask

    task automatic set_src(input int i, input logic v, input logic s, input logic e,
                           input logic [2:0] m, input logic [63:0] d);
        req_val[i] = v; req_sop[i] = s; req_eop[i] = e;
        req_mod[i*3 +: 3] = m; req_data[i*64 +: 64] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    function automatic vec_t mk(int src, logic v, logic s, logic e, logic [2:0] m, logic f,
                                logic ev, logic es, logic ee, logic [2:0] em,
                                logic [3:0] erdy, logic [2:0] egid);
        vec_t r;
        r.src = src; r.v = v; r.s = s; r.e = e; r.m = m; r.f = f;
        r.ev = ev; r.es = es; r.ee = ee; r.em = em; r.erdy = erdy; r.egid = egid;
        return r;
    endfunction

    initial begin
        int beat[N];
        int exp_id, frames, cur, id, pcycles;
        bit inter, got, pulsed, bad, sop_after, eop_in_pause;
        logic [N-1:0] rs;

        // single requester frames, 1-beat frame, then a stalled 4-beat frame on requester 2
        tbl.push_back(mk(0,1,1,0,0,0, 0,0,0,0,4'b0000,0));
        tbl.push_back(mk(0,1,1,0,0,0, 1,1,0,0,4'b0001,0));
        tbl.push_back(mk(0,1,0,0,0,0, 1,0,0,0,4'b0001,0));
        tbl.push_back(mk(0,1,0,1,5,0, 1,0,1,5,4'b0001,0));
        tbl.push_back(mk(0,1,1,1,0,0, 0,0,0,0,4'b0000,0));
        tbl.push_back(mk(0,1,1,1,0,0, 0,0,0,0,4'b0000,0));
        tbl.push_back(mk(0,1,1,1,0,0, 1,1,1,0,4'b0001,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,4'b0000,0));
        tbl.push_back(mk(2,1,1,0,0,0, 0,0,0,0,4'b0000,0));
        tbl.push_back(mk(2,1,1,0,0,0, 1,1,0,0,4'b0100,2));
        tbl.push_back(mk(2,1,0,0,0,0, 1,0,0,0,4'b0100,2));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(2,1,0,0,0,1, 0,0,0,0,4'b0000,2));
        tbl.push_back(mk(2,1,0,0,0,0, 1,0,0,0,4'b0100,2));
        tbl.push_back(mk(2,1,0,1,3,0, 1,0,1,3,4'b0100,2));
        tbl.push_back(mk(2,0,0,0,0,0, 0,0,0,0,4'b0000,2));

        rst = 1'b1;
        clr_in();
        tick();
        do_reset();
        chk("reset_outs", {pkt_tx_val, pkt_tx_sop, pkt_tx_eop, req_rdy, paused, err_nosop, grant_id}, 64'h0);
        chk("reset_frame_cnt", 64'(frame_cnt), 64'h0);

        foreach (tbl[r]) begin
            clr_in();
            set_src(tbl[r].src, tbl[r].v, tbl[r].s, tbl[r].e, tbl[r].m, 64'hD0D0_0000_0000_0000 | 64'(r));
            full = tbl[r].f;
            #1;
            chk($sformatf("vec%0d", r),
                64'({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, req_rdy, grant_id}),
                64'({tbl[r].ev, tbl[r].es, tbl[r].ee, tbl[r].em, tbl[r].erdy, tbl[r].egid}));
            if (tbl[r].ev)
                chk($sformatf("vec%0d_data", r), pkt_tx_data, 64'hD0D0_0000_0000_0000 | 64'(r));
            tick();
        end
        chk("table_frame_cnt", 64'(frame_cnt), 64'd3);

        // four requesters with back-to-back 2-beat frames
        do_reset();
        beat = '{default: 0};
        exp_id = 0; frames = 0; cur = -1; inter = 0;
        for (int c = 0; c < 200 && frames < 8; c++) begin
            for (int i = 0; i < N; i++)
                set_src(i, 1'b1, beat[i] == 0, beat[i] == 1, 3'd0, 64'(i * 16 + beat[i]));
            #1;
            if (pkt_tx_val) begin
                id = int'(pkt_tx_data[7:4]);
                if (pkt_tx_sop) begin
                    chk($sformatf("rr_grant%0d", exp_id), 64'(id), 64'(exp_id % N));
                    exp_id++;
                    cur = id;
                end else if (id != cur) inter = 1;
                if (pkt_tx_eop) frames++;
            end
            rs = req_rdy;
            tick();
            for (int i = 0; i < N; i++)
                if (rs[i]) beat[i] = 1 - beat[i];
        end
        chk("rr_frames_seen", 64'(frames), 64'd8);
        chk("rr_no_interleave", 64'(inter), 64'd0);
        chk("rr_frame_cnt", 64'(frame_cnt), 64'd8);

        // one frame on requester 1 moves the pointer to 2, then reset mid-frame on requester 2
        clr_in();
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            set_src(1, 1'b1, 1'b1, 1'b1, 3'd0, 64'h11);
            #1;
            got = pkt_tx_val;
            tick();
        end
        chk("req1_frame", 64'(got), 64'd1);
        clr_in();
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            set_src(2, 1'b1, 1'b1, 1'b0, 3'd0, 64'h20);
            #1;
            got = pkt_tx_val;
            if (got) begin
                pause_req = 1'b1;
                pause_quanta = 16'd5;
            end
            tick();
        end
        chk("req2_sop", 64'(got), 64'd1);
        pause_req = 1'b0;
        set_src(2, 1'b1, 1'b0, 1'b0, 3'd0, 64'h21);
        rst = 1'b1;
        #1;
        chk("during_reset", 64'({pkt_tx_val, req_rdy, paused}), 64'h0);
        tick();
        rst = 1'b0;
        clr_in();
        set_src(0, 1'b1, 1'b1, 1'b0, 3'd0, 64'h0);
        set_src(2, 1'b1, 1'b1, 1'b0, 3'd0, 64'h22);
        #1;
        chk("post_reset_state", 64'({pkt_tx_val, req_rdy, paused, grant_id}), 64'h0);
        chk("post_reset_frame_cnt", 64'(frame_cnt), 64'd0);
        tick();
        chk("post_reset_grant", 64'({pkt_tx_val, pkt_tx_sop, grant_id, req_rdy}), 64'({1'b1, 1'b1, 3'd0, 4'b0001}));

        // pause pulse during beat 2 of a 4-beat frame
        do_reset();
        beat[0] = 0; pulsed = 0; pcycles = 0; bad = 0; sop_after = 0; eop_in_pause = 0;
        for (int c = 0; c < 80 && !sop_after; c++) begin
            set_src(0, 1'b1, beat[0] == 0, beat[0] == 3, 3'd0, 64'(beat[0]));
            #1;
            if (paused) pcycles++;
            if (pkt_tx_val) begin
                if (pkt_tx_sop && paused) bad = 1;
                if (pkt_tx_sop && pulsed) sop_after = 1;
                if (pkt_tx_eop && paused) eop_in_pause = 1;
            end
            if (!pulsed && pkt_tx_val && beat[0] == 1) begin
                pause_req = 1'b1;
                pause_quanta = 16'd2;
                pulsed = 1;
            end
            rs = req_rdy;
            tick();
            pause_req = 1'b0;
            if (rs[0]) beat[0] = (beat[0] + 1) % 4;
        end
        chk("pause_cycles", 64'(pcycles), 64'd16);
        chk("pause_frame_done", 64'(eop_in_pause), 64'd1);
        chk("pause_no_sop", 64'(bad), 64'd0);
        chk("pause_resume", 64'(sop_after), 64'd1);

        // cancel a running pause with quanta=0
        do_reset();
        pause_req = 1'b1;
        pause_quanta = 16'd2;
        tick();
        pause_req = 1'b0;
        chk("pause_set", 64'(paused), 64'd1);
        pause_req = 1'b1;
        pause_quanta = 16'd0;
        tick();
        pause_req = 1'b0;
        chk("pause_cancel", 64'(paused), 64'd0);

        // stray non-SOP beat while idle
        do_reset();
        set_src(1, 1'b1, 1'b0, 1'b0, 3'd0, 64'h55);
        #1;
        chk("nosop_drain", 64'({pkt_tx_val, req_rdy, err_nosop}), 64'({1'b0, 4'b0010, 1'b0}));
        tick();
        clr_in();
        #1;
        chk("nosop_set", 64'({pkt_tx_val, req_rdy, err_nosop}), 64'({1'b0, 4'b0000, 1'b1}));
        repeat (4) tick();
        chk("nosop_sticky", 64'(err_nosop), 64'd1);
        do_reset();
        chk("nosop_cleared", 64'(err_nosop), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
